pipelined_csla: RTL
===================

Name: pipelined_csla

Overview:
- Parametrised, pipelined carry-select adder/subtractor: successor to the fixed 32-bit combinational carry-select adder.
- Splits the WIDTH-bit operation into NBLK = WIDTH/BLOCK carry-select blocks, with one pipeline register stage per block.
- Throughput is one operation per clock, with valid/ready flow control at both ends.
- Adds a subtract mode, a signed-overflow flag and full back-pressure, so it can sit between handshaked datapath stages.

Parameters:
- WIDTH, 32, operand/result width; must be a multiple of BLOCK.
- BLOCK, 8, carry-select block width; BLOCK >= 2 and WIDTH >= BLOCK. Latency is NBLK = WIDTH/BLOCK cycles.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand set valid.
- in_ready  output  1  block can accept an operand set this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in (borrow-in when sub=1, see Behaviour).
- sub  input  1  0 = add, 1 = subtract.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result.
- cout  output  1  carry out of MSB (for subtract: 1 = no borrow).
- ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB.
- busy  output  1  any pipeline stage holds a valid entry.

Behaviour:
- Effective operands: be = b XOR {WIDTH{sub}}, ce = cin XOR sub. Result is a + be + ce.
  - sub=1, cin=0 gives a - b; sub=1, cin=1 gives a - b - 1.
- Stage k (k = 0..NBLK-1):
  - Computes block k, bits [k*BLOCK +: BLOCK], as two candidates: carry-in 0 and carry-in 1.
  - Selects the candidate using the carry registered by stage k-1 (stage 0 uses ce).
  - Registers the selected slice, the block carry-out and a valid bit.
  - Unprocessed upper operand bits travel with the entry in stage registers.
- Last stage also registers carry-into-MSB for ovf.
- Global advance enable: en = !out_valid || out_ready. in_ready = en (combinational).
  - When en=0, every stage holds its contents.
  - Bubbles are not collapsed.
- Accept happens when in_valid && in_ready. Stage-0 valid loads in_valid on en.
- Latency: an operand accepted at edge N yields out_valid=1 after edge N+NBLK-1, i.e. NBLK cycles from presentation to registered output, absent stalls. Each stall cycle adds one.
- Output handshake:
  - sum/cout/ovf are stable while out_valid && !out_ready.
  - A result is consumed on out_valid && out_ready.
  - Simultaneous consume and new accept in the same cycle is permitted; throughput is 1/cycle.
- Ordering: results emerge in acceptance order, with no loss or duplication.
- busy = OR of all stage valid bits.
- Reset (async assert, any time, including mid-operation):
  - All valid bits, sum, cout and ovf go to 0 immediately.
  - in_ready = 1 while out_valid = 0.
  - In-flight operations are discarded; no stale result appears after release.
- Reset release is registered internally; the first accept may occur on the first rising edge after rst_n rises.
- Arithmetic wraps modulo 2^WIDTH. cout/ovf report the wrap.
- Inputs a/b/cin/sub are don't-care when in_valid=0.

Test Plan:
- Reset values, WIDTH=32/BLOCK=8: hold rst_n=0 -> out_valid=0, sum=0, cout=0, ovf=0, busy=0, in_ready=1.
- Add with carry ripple: a=0xFFFFFFFF, b=0, cin=1, sub=0, out_ready=1 -> after 4 cycles sum=0x00000000, cout=1, ovf=0, out_valid high for exactly 1 cycle.
- Signed overflow: a=0x7FFFFFFF, b=0x00000001, cin=0 -> sum=0x80000000, cout=0, ovf=1.
- Subtract: a=5, b=7, sub=1, cin=0 -> sum=0xFFFFFFFE, cout=0, ovf=0. Then a=7, b=5, sub=1 -> sum=0x00000002, cout=1.
- Back-pressure stream:
  - Stimulus: 16 back-to-back random operand sets with out_ready pattern 1,0,0,1,1,0 repeating.
  - Required: results match a reference model in order, no loss/dup, in_ready==0 exactly when out_valid && !out_ready, and outputs stable during stalls.
- Reset mid-flight and second configuration:
  - Pulse rst_n low asynchronously (between edges) with 3 entries in flight -> out_valid and busy drop immediately; no output appears after release until new input.
  - Rerun the above scenarios with WIDTH=16, BLOCK=4 -> latency 4, e.g. 0xFFFF+0x0001 gives sum=0x0000, cout=1.

Source files
------------

// File: rtl/pipelined_csla.sv
// Pipelined carry-select adder/subtractor.
// The operation is split into NBLK = WIDTH/BLOCK blocks. Stage k resolves
// block k by selecting between two precomputed candidates (carry-in 0/1)
// using the carry registered by stage k-1. A single global enable gives
// valid/ready flow control with full back-pressure.
module pipelined_csla #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned BLOCK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NBLK = WIDTH / BLOCK;

  // Per-stage registers: operands travel with the entry so later stages
  // can still see the upper, not yet processed, bits.
  logic [WIDTH-1:0] a_q  [NBLK];
  logic [WIDTH-1:0] be_q [NBLK];
  logic [WIDTH-1:0] s_q  [NBLK];
  logic [NBLK-1:0]  c_q;
  logic [NBLK-1:0]  vld_q;
  logic             ovf_q;

  // Stage inputs (stage 0 from the ports, stage k from stage k-1 registers)
  logic [WIDTH-1:0] src_a [NBLK];
  logic [WIDTH-1:0] src_b [NBLK];
  logic [WIDTH-1:0] src_s [NBLK];
  logic [NBLK-1:0]  src_c;
  logic [NBLK-1:0]  src_v;

  // Per-stage next-state values
  logic [BLOCK:0]   cand0 [NBLK];
  logic [BLOCK:0]   cand1 [NBLK];
  logic [BLOCK:0]   sel   [NBLK];
  logic [WIDTH-1:0] s_d   [NBLK];
  logic [NBLK-1:0]  c_d;
  logic             ovf_d;

  logic en;

  assign en        = !vld_q[NBLK-1] || out_ready;
  assign in_ready  = en;
  assign out_valid = vld_q[NBLK-1];
  assign sum       = s_q[NBLK-1];
  assign cout      = c_q[NBLK-1];
  assign ovf       = ovf_q;
  assign busy      = |vld_q;

  // Route each stage's inputs: effective operands into stage 0, registers onward
  always_comb begin
    src_a[0] = a;
    src_b[0] = b ^ {WIDTH{sub}};
    src_s[0] = '0;
    src_c    = '0;
    src_v    = '0;
    src_c[0] = cin ^ sub;
    src_v[0] = in_valid;
    for (int unsigned k = 1; k < NBLK; k++) begin
      src_a[k] = a_q[k-1];
      src_b[k] = be_q[k-1];
      src_s[k] = s_q[k-1];
      src_c[k] = c_q[k-1];
      src_v[k] = vld_q[k-1];
    end
  end

  // Carry-select per block: both candidates, then pick with the incoming carry
  always_comb begin
    c_d = '0;
    for (int unsigned k = 0; k < NBLK; k++) begin
      cand0[k] = {1'b0, src_a[k][k*BLOCK +: BLOCK]} + {1'b0, src_b[k][k*BLOCK +: BLOCK]};
      cand1[k] = {1'b0, src_a[k][k*BLOCK +: BLOCK]} + {1'b0, src_b[k][k*BLOCK +: BLOCK]}
                 + {{BLOCK{1'b0}}, 1'b1};
      sel[k]   = src_c[k] ? cand1[k] : cand0[k];
      s_d[k]   = src_s[k];
      s_d[k][k*BLOCK +: BLOCK] = sel[k][BLOCK-1:0];
      c_d[k]   = sel[k][BLOCK];
    end
    // carry into the MSB recovered as a^b^s at that bit
    ovf_d = (src_a[NBLK-1][WIDTH-1] ^ src_b[NBLK-1][WIDTH-1] ^ s_d[NBLK-1][WIDTH-1])
            ^ c_d[NBLK-1];
  end

  // Pipeline registers: all stages advance together on en, hold otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < NBLK; k++) begin
        a_q[k]  <= '0;
        be_q[k] <= '0;
        s_q[k]  <= '0;
      end
    end else if (en) begin
      vld_q <= src_v;
      for (int unsigned k = 0; k < NBLK; k++) begin
        if (src_v[k]) begin
          a_q[k]  <= src_a[k];
          be_q[k] <= src_b[k];
          s_q[k]  <= s_d[k];
          c_q[k]  <= c_d[k];
        end
      end
      if (src_v[NBLK-1]) ovf_q <= ovf_d;
    end
  end

endmodule
